// File: rtl/edge_pkg.sv
// Shared types and constants for the edge playback block.
package edge_pkg;

  localparam int unsigned EDGE_PKG_DEFAULT_TW = 32;

  // Timestamp at the default width; parameterised instances size their own vectors.
  typedef logic [EDGE_PKG_DEFAULT_TW-1:0] ts_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } player_state_e;

endpackage : edge_pkg

// File: rtl/edge_fifo.sv
// Synchronous timestamp FIFO with registered occupancy count.
// Push is ignored when full and pop is ignored when empty.
module edge_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TW-1:0]          din,
  input  logic                   pop,
  output logic [TW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests against occupancy and compute next pointers/count.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : edge_fifo

// File: rtl/edge_player.sv
// Replays buffered clock-edge timestamps as single-cycle pulses against a
// free-running time counter. A timestamp fires one cycle after it comes due;
// anything already in the past (within half the counter range) fires at once
// and raises the sticky late flag.
module edge_player
  import edge_pkg::*;
#(
  parameter int unsigned TW    = EDGE_PKG_DEFAULT_TW,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [TW-1:0]          ts_data,
  input  logic                   ts_valid,
  output logic                   ts_ready,
  output logic                   edge_pulse,
  output logic [TW-1:0]          now,
  output logic [$clog2(DEPTH):0] level,
  output logic                   late
);

  player_state_e state_q, state_d;
  logic [TW-1:0] now_q, now_d;
  logic          pulse_q, pulse_d;
  logic          late_q, late_d;

  logic [TW-1:0] head;
  logic [TW-1:0] diff;
  logic          full, empty;
  logic          due, overdue, pop;

  edge_fifo #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (ts_valid),
    .din   (ts_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  assign ts_ready   = !full;
  assign edge_pulse = pulse_q;
  assign now        = now_q;
  assign late       = late_q;

  // Modular compare of the head timestamp against the current time.
  always_comb begin
    diff    = head - now_q;
    due     = (diff == '0);
    overdue = diff[TW-1];
    pop     = (state_q == RUN) && !empty && (due || overdue);
    pulse_d = pop;
    late_d  = late_q | (pop && overdue);
  end

  // Mode sequencing and time counter advance.
  always_comb begin
    state_d = state_q;
    now_d   = now_q;
    unique case (state_q)
      IDLE: begin
        now_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        now_d = now_q + TW'(1);
        if (!enable) state_d = PAUSE;
      end
      PAUSE: begin
        if (enable) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        now_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      now_q   <= '0;
      pulse_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      now_q   <= now_d;
      pulse_q <= pulse_d;
      late_q  <= late_d;
    end
  end

endmodule : edge_player

// File: tb/tb_edge_player.sv
// Bench for edge_player: a 32-bit and an 8-bit instance driven cycle by cycle,
// each checked against a queue-based model of the playback rules.
module tb_edge_player;

  localparam int unsigned DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, ts_valid, ts_ready, edge_pulse, late;
  logic [31:0] ts_data, now;
  logic [3:0]  level;
  logic        enable8, ts_valid8, ts_ready8, edge_pulse8, late8;
  logic [7:0]  ts_data8, now8;
  logic [3:0]  level8;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state, index 0 = 32-bit instance, index 1 = 8-bit instance.
  longint unsigned q0[$];
  longint unsigned q1[$];
  longint unsigned m_now[2];
  bit              m_run[2];
  bit              m_late[2];
  bit              m_pulse[2];

  // Times (DUT now) at which the DUT showed a pulse, per instance.
  longint unsigned dlog0[$];
  longint unsigned dlog1[$];

  always #5 clock = ~clock;

  edge_player #(.TW(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .edge_pulse(edge_pulse),
    .now(now), .level(level), .late(late)
  );

  edge_player #(.TW(8), .DEPTH(DEPTH)) dut8 (
    .clock(clock), .reset(reset), .enable(enable8), .ts_data(ts_data8),
    .ts_valid(ts_valid8), .ts_ready(ts_ready8), .edge_pulse(edge_pulse8),
    .now(now8), .level(level8), .late(late8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge of the playback rules. The counter advances on an edge
  // iff enable was seen high on the previous edge; compares happen under
  // the same condition.
  task automatic model_ch(input int ch, input bit rst, input bit en,
                          input bit v, input longint unsigned d);
    longint unsigned mask, half, hd, dd;
    int sz;
    bit pop;
    mask = (ch == 0) ? 64'hFFFF_FFFF : 64'hFF;
    half = (mask + 1) >> 1;
    if (rst) begin
      if (ch == 0) q0.delete(); else q1.delete();
      m_now[ch] = 0; m_run[ch] = 0; m_late[ch] = 0; m_pulse[ch] = 0;
      return;
    end
    sz  = (ch == 0) ? q0.size() : q1.size();
    pop = 0;
    hd  = 0;
    if (m_run[ch] && sz > 0) begin
      if (ch == 0) hd = q0[0]; else hd = q1[0];
      dd = (hd - m_now[ch]) & mask;
      if (dd == 0 || dd >= half) begin
        pop = 1;
        if (dd != 0) m_late[ch] = 1;
      end
    end
    m_pulse[ch] = pop;
    if (pop) begin
      if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (v && sz < int'(DEPTH)) begin
      if (ch == 0) q0.push_back(d & mask); else q1.push_back(d & mask);
    end
    if (m_run[ch]) m_now[ch] = (m_now[ch] + 1) & mask;
    m_run[ch] = en;
  endtask

  task automatic step(input bit rst, input bit en, input bit v, input longint unsigned d,
                      input bit en8, input bit v8, input longint unsigned d8);
    reset     = rst;
    enable    = en;
    ts_valid  = v;
    ts_data   = d[31:0];
    enable8   = en8;
    ts_valid8 = v8;
    ts_data8  = d8[7:0];
    @(posedge clock);
    model_ch(0, rst, en, v, d);
    model_ch(1, rst, en8, v8, d8);
    #1;
    chk("pulse32", 64'(edge_pulse), 64'(m_pulse[0]));
    chk("now32",   64'(now),        m_now[0]);
    chk("level32", 64'(level),      64'(q0.size()));
    chk("late32",  64'(late),       64'(m_late[0]));
    chk("ready32", 64'(ts_ready),   64'(q0.size() < int'(DEPTH)));
    chk("pulse8",  64'(edge_pulse8), 64'(m_pulse[1]));
    chk("now8",    64'(now8),        m_now[1]);
    chk("level8",  64'(level8),      64'(q1.size()));
    chk("late8",   64'(late8),       64'(m_late[1]));
    chk("ready8",  64'(ts_ready8),   64'(q1.size() < int'(DEPTH)));
    if (edge_pulse === 1'b1)  dlog0.push_back(64'(now));
    if (edge_pulse8 === 1'b1) dlog1.push_back(64'(now8));
  endtask

  task automatic s32(input bit rst, input bit en, input bit v, input longint unsigned d);
    step(rst, en, v, d, 1'b0, 1'b0, 0);
  endtask

  task automatic clear_logs();
    dlog0.delete();
    dlog1.delete();
  endtask

  task automatic run32_until(input longint unsigned target);
    for (int i = 0; i < 1000 && m_now[0] != target; i++) s32(0, 1, 0, 0);
    chk("reach32", 64'(now), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; enable = 0; ts_valid = 0; ts_data = '0;
    enable8 = 0; ts_valid8 = 0; ts_data8 = '0;

    // Reset values.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 64'(ts_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    s32(0, 0, 0, 0);

    // Basic playback: 5, 10, 12 fire at now = 6, 11, 13.
    clear_logs();
    s32(0, 0, 1, 5);
    s32(0, 0, 1, 10);
    s32(0, 0, 1, 12);
    chk("t1_level3", 64'(level), 64'd3);
    for (int i = 0; i < 16; i++) s32(0, 1, 0, 0);
    chk("t1_npulse", 64'(dlog0.size()), 64'd3);
    if (dlog0.size() == 3) begin
      chk("t1_p0", dlog0[0], 64'd6);
      chk("t1_p1", dlog0[1], 64'd11);
      chk("t1_p2", dlog0[2], 64'd13);
    end
    chk("t1_late", 64'(late), 64'd0);
    chk("t1_level0", 64'(level), 64'd0);

    // Fill the buffer while paused; the ninth push is refused.
    s32(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 8; i++) s32(0, 0, 1, 64'(100 + i));
    chk("t2_ready", 64'(ts_ready), 64'd0);
    s32(0, 0, 1, 999);
    s32(0, 0, 1, 999);
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_npulse", 64'(dlog0.size()), 64'd0);

    // Pause mid-run: counter freezes, pulse still lands at now = 21.
    s32(1, 0, 0, 0);
    clear_logs();
    s32(0, 0, 1, 20);
    run32_until(9);
    for (int i = 0; i < 15; i++) s32(0, 0, 0, 0);
    chk("t3_frozen", 64'(now), 64'd10);
    for (int i = 0; i < 15; i++) s32(0, 1, 0, 0);
    chk("t3_npulse", 64'(dlog0.size()), 64'd1);
    if (dlog0.size() == 1) chk("t3_p0", dlog0[0], 64'd21);

    // Duplicate and backwards timestamps play back to back and flag late.
    s32(1, 0, 0, 0);
    clear_logs();
    s32(0, 0, 1, 3);
    s32(0, 0, 1, 3);
    s32(0, 0, 1, 2);
    for (int i = 0; i < 10; i++) s32(0, 1, 0, 0);
    chk("t4_npulse", 64'(dlog0.size()), 64'd3);
    if (dlog0.size() == 3) begin
      chk("t4_p0", dlog0[0], 64'd4);
      chk("t4_p1", dlog0[1], 64'd5);
      chk("t4_p2", dlog0[2], 64'd6);
    end
    chk("t4_late", 64'(late), 64'd1);

    // 8-bit wrap: at now = 250 a push of 4 is in the future.
    step(1, 0, 0, 0, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 1000 && m_now[1] != 250; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("t5_reach", 64'(now8), 64'd250);
    step(0, 0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("t5_npulse", 64'(dlog1.size()), 64'd1);
    if (dlog1.size() == 1) chk("t5_p0", dlog1[0], 64'd5);
    chk("t5_late", 64'(late8), 64'd0);

    // Reset mid-run discards the pending timestamp.
    s32(1, 0, 0, 0);
    clear_logs();
    s32(0, 0, 1, 50);
    run32_until(20);
    s32(1, 1, 0, 0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_now", 64'(now), 64'd0);
    for (int i = 0; i < 5; i++) s32(0, 0, 0, 0);
    chk("t6_idle_now", 64'(now), 64'd0);
    for (int i = 0; i < 60; i++) s32(0, 1, 0, 0);
    chk("t6_npulse", 64'(dlog0.size()), 64'd0);

    // Randomized traffic on both instances.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit en, v, en8, v8;
      longint unsigned d, d8;
      en  = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 2) == 0);
      d   = (m_now[0] + 64'($urandom_range(0, 40)) - 64'd5) & 64'hFFFF_FFFF;
      en8 = ($urandom_range(0, 9) != 0);
      v8  = ($urandom_range(0, 2) == 0);
      d8  = 64'($urandom_range(0, 255));
      step(0, en, v, d, en8, v8, d8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_edge_player

// File: doc/edge_player.md
Name: edge_player

Overview:
Replays a recorded list of clock-edge timestamps as single-cycle pulses on a synthesizable clock domain. It is the playback counterpart to edge-time capture: the bench or a loader pushes timestamps over a valid/ready stream. A free-running time counter fires `edge_pulse` when each timestamp comes due. It is used to drive PLL/DCO models and check blocks with a known edge sequence.

Parameters:
TW, 32, timestamp and time-counter width in bits; units are `clock` cycles.
DEPTH, 8, timestamp buffer depth in entries; must be a power of 2 and at least 2.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  high = time counter runs and edges play; low = pause.
ts_data  input  TW  edge timestamp, in `clock` cycles since the first enabled cycle.
ts_valid  input  1  `ts_data` valid.
ts_ready  output  1  buffer can accept; equal to `!full`.
edge_pulse  output  1  registered, one-cycle pulse per played edge.
now  output  TW  current time counter value.
level  output  $clog2(DEPTH)+1  number of buffered timestamps.
late  output  1  sticky flag: an edge was played after its due time.

Behaviour:
- Reset: `edge_pulse`=0, `now`=0, `level`=0, `late`=0, `ts_ready`=1. Buffer flushed. State=IDLE. Reset mid-operation discards all buffered timestamps.
- Push: accepted when `ts_valid && ts_ready`.
  - Written at that clock edge.
  - Visible as head from the next cycle.
  - `ts_ready` depends only on `full`, not on a same-cycle pop; at full, a simultaneous pop does not allow a push.
- State machine:
  - IDLE: `now` held at 0, no compares. Goes to RUN when `enable`=1.
  - RUN: `now` increments by 1 every cycle, wrapping modulo 2^TW. Goes to PAUSE when `enable`=0.
  - PAUSE: `now` frozen, no compares, buffer retained and pushes still accepted. Goes to RUN when `enable`=1.
  - Only reset returns the block to IDLE.
- Compare, in RUN only, when the buffer is non-empty:
  - `diff = head - now`, computed in TW bits modulo 2^TW.
  - `diff == 0`: due. Pop the head, and assert `edge_pulse` in the next cycle. The pulse is therefore high in the cycle where `now == ts+1`.
  - `diff[TW-1] == 1`: overdue (past time, within a 2^(TW-1) window). Pop, pulse next cycle, and set `late`=1 (sticky until reset).
  - Otherwise: wait.
  - At most one pop per cycle. Duplicate or non-monotonic timestamps play on consecutive cycles and flag `late`.
- Empty buffer in RUN: no pulse, `now` keeps counting; not an error.
- Enable falling in the same cycle as a due match: the compare uses the current state (RUN), so the pop and pulse still occur.
- `level` updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.

Decomposition:
- Package `edge_pkg`: `ts_t` (`logic [TW-1:0]` via a parameterised typedef or a default-width constant), the `player_state_e` enum {IDLE, RUN, PAUSE}, and a `EDGE_PKG_DEFAULT_TW` constant.
- Sub-module `edge_fifo`: synchronous FIFO (DEPTH, TW) with `push`, `pop`, `head`, `full`, `empty` and `count`. The `edge_player` top holds the FSM, the counter, the compare and the output registers.

Test Plan:
- Reset, then push 5, 10, 12 and raise `enable` at cycle 0 of RUN → `edge_pulse` high exactly when `now` = 6, 11, 13; `late`=0; `level` returns to 0.
- Push 8 entries with `enable`=0 → `ts_ready`=0 after the 8th; the 9th is held; `level`=8; no pulses.
- Push 20, run to `now`=10, drop `enable` for 15 cycles, then raise it → `now` frozen at 10 during the pause; pulse at `now`=21; pause length has no effect.
- Push 3, 3, 2 → pulses on three consecutive cycles starting at `now`=4; `late`=1 from the second pop onward.
- TW=8: run until `now`=250, then push 4 → treated as future (`diff`=10); pulse at `now`=5 after the wrap; `late`=0.
- Push 50, assert `reset` at `now`=20 → `level`=0, `now`=0, state IDLE, and no pulse ever appears for 50.
